// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO feeding a combinational ALU, with a
// registered result presented to the consumer over valid/ready.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o  producer handshake
//   cmd_a_i, cmd_b_i, cmd_op_i command operands and opcode
//   alu_a_o, alu_b_o, alu_op_o FIFO head driven to the ALU (0 when empty)
//   alu_res_i                  combinational ALU result
//   res_valid_o / res_ready_i  consumer handshake
//   res_data_o, res_op_o       registered result and its opcode
//   count_o                    FIFO occupancy, 0..DEPTH
module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [7:0]               cmd_a_i,
    input  logic [7:0]               cmd_b_i,
    input  logic [2:0]               cmd_op_i,
    output logic [7:0]               alu_a_o,
    output logic [7:0]               alu_b_o,
    output logic [2:0]               alu_op_o,
    input  logic [7:0]               alu_res_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [7:0]               res_data_o,
    output logic [2:0]               res_op_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    cmd_t            mem [DEPTH];
    cmd_t            head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            res_valid;
    logic [7:0]      res_data;
    logic [2:0]      res_op;
    logic            push;
    logic            issue;
    logic            empty;

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Ready looks only at registered occupancy: no pop-to-push bypass.
    assign cmd_ready_o = (count != FULL);
    assign push        = cmd_valid_i && cmd_ready_o;

    // Issue whenever the result register is free or being drained.
    assign issue = !empty && (!res_valid || res_ready_i);

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = '0;
        if (!empty) begin
            alu_a_o  = head.a;
            alu_b_o  = head.b;
            alu_op_o = head.op;
        end
    end

    always_comb begin
        count_nxt = count;
        unique case ({push, issue})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: cmd_a_i, b: cmd_b_i, op: cmd_op_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
        end else begin
            count <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr    <= rd_ptr + AW'(1);
                res_data  <= alu_res_i;
                res_op    <= head.op;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready_i) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign res_valid_o = res_valid;
    assign res_data_o  = res_data;
    assign res_op_o    = res_op;
    assign count_o     = count;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: directed stimulus with a scoreboard queue and an
// independent monitor checking results, order and stability.
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] cmd_a_i;
    logic [7:0] cmd_b_i;
    logic [2:0] cmd_op_i;
    logic [7:0] alu_a_o;
    logic [7:0] alu_b_o;
    logic [2:0] alu_op_o;
    logic [7:0] alu_res_i;
    logic       res_valid_o;
    logic       res_ready_i;
    logic [7:0] res_data_o;
    logic [2:0] res_op_o;
    logic [$clog2(DEPTH):0] count_o;

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_a_i     (cmd_a_i),
        .cmd_b_i     (cmd_b_i),
        .cmd_op_i    (cmd_op_i),
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_op_o    (alu_op_o),
        .alu_res_i   (alu_res_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_data_o  (res_data_o),
        .res_op_o    (res_op_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the downstream ALU.
    always_comb begin
        alu_res_i = 8'h00;
        case (alu_op_o)
            3'b000: alu_res_i = alu_a_o + alu_b_o;
            3'b001: alu_res_i = alu_a_o - alu_b_o;
            3'b010: alu_res_i = alu_a_o << alu_b_o[2:0];
            3'b011: alu_res_i = alu_a_o >> alu_b_o[2:0];
            3'b100: alu_res_i = alu_a_o & alu_b_o;
            3'b101: alu_res_i = alu_a_o | alu_b_o;
            3'b110: alu_res_i = alu_a_o ^ alu_b_o;
            default: alu_res_i = {7'd0, alu_a_o == alu_b_o};
        endcase
    end

    typedef struct {
        logic [7:0] data;
        logic [2:0] op;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every handshake; checks hold under backpressure.
    logic       hold = 1'b0;
    logic [7:0] hold_d;
    logic [2:0] hold_op;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", int'(res_valid_o), 1);
                check("hold_data", int'(res_data_o), int'(hold_d));
                check("hold_op", int'(res_op_o), int'(hold_op));
            end
            hold    = res_valid_o && !res_ready_i;
            hold_d  = res_data_o;
            hold_op = res_op_o;
            if (res_valid_o && res_ready_i) begin
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got 0x%0h expected none",
                             res_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", int'(res_data_o), int'(e.data));
                    check("res_op", int'(res_op_o), int'(e.op));
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input logic [7:0] exp);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        cmd_valid_i = 1'b1;
        cmd_a_i     = a;
        cmd_b_i     = b;
        cmd_op_i    = op;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready_o && n < 50);
        if (!cmd_ready_o) begin
            check("send_timeout", 0, 1);
        end else begin
            e.data = exp;
            e.op   = op;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    logic [7:0] t_a  [6] = '{8'h01, 8'h10, 8'hF0, 8'h0F, 8'hFF, 8'h80};
    logic [7:0] t_b  [6] = '{8'h02, 8'h01, 8'h3C, 8'h30, 8'h0F, 8'h03};
    logic [2:0] t_op [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b011};
    logic [7:0] t_r  [6] = '{8'h03, 8'h0F, 8'h30, 8'h3F, 8'hF0, 8'h10};

    initial begin
        exp_t e;
        int   k;
        reset       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_a_i     = '0;
        cmd_b_i     = '0;
        cmd_op_i    = '0;
        res_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_count", int'(count_o), 0);
        check("rst_ready", int'(cmd_ready_o), 1);
        check("rst_valid", int'(res_valid_o), 0);
        check("rst_data", int'(res_data_o), 0);
        check("rst_op", int'(res_op_o), 0);
        check("rst_alu", int'({alu_a_o, alu_b_o, alu_op_o}), 0);

        // Single ADD: latency and occupancy.
        send(8'h7F, 8'h01, 3'b000, 8'h80);
        idle();
        @(negedge clk);
        check("lat_count1", int'(count_o), 1);
        check("lat_valid0", int'(res_valid_o), 0);
        @(negedge clk);
        check("lat_count0", int'(count_o), 0);
        check("lat_valid1", int'(res_valid_o), 1);
        check("lat_data", int'(res_data_o), 8'h80);
        drain("lat_drain");

        // Back-to-back, no bubbles.
        pop_cyc.delete();
        send(8'hFF, 8'h02, 3'b000, 8'h01);
        send(8'h05, 8'h07, 3'b001, 8'hFE);
        send(8'h3C, 8'h3C, 3'b111, 8'h01);
        send(8'h81, 8'h09, 3'b010, 8'h02);
        idle();
        drain("b2b_drain");
        repeat (2) @(negedge clk);
        check("b2b_pops", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) begin
                check("b2b_gap", pop_cyc[i] - pop_cyc[i-1], 1);
            end
        end

        // Full backpressure: DEPTH+1 accepted.
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            cmd_valid_i = (k < 6);
            cmd_a_i     = t_a[k % 6];
            cmd_b_i     = t_b[k % 6];
            cmd_op_i    = t_op[k % 6];
            @(negedge clk);
            if (cmd_valid_i && cmd_ready_o) begin
                e.data = t_r[k];
                e.op   = t_op[k];
                exp_q.push_back(e);
                k++;
            end
        end
        idle();
        @(negedge clk);
        check("bp_accepted", k, 5);
        check("bp_count", int'(count_o), DEPTH);
        check("bp_ready", int'(cmd_ready_o), 0);
        check("bp_data", int'(res_data_o), 8'h03);
        @(posedge clk); #1;
        res_ready_i = 1'b1;
        @(negedge clk);
        check("bp_ready_pre", int'(cmd_ready_o), 0);
        @(negedge clk);
        check("bp_ready_post", int'(cmd_ready_o), 1);
        drain("bp_drain");

        // Sustained XOR stream across pointer wrap.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            send(8'h10 + 8'(i), 8'hAA, 3'b110, (8'h10 + 8'(i)) ^ 8'hAA);
            if (i >= 2) check("ss_count", int'(count_o), 1);
        end
        idle();
        drain("ss_drain");

        // Reset with queued commands and a pending result.
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        send(8'h01, 8'h01, 3'b000, 8'h02);
        send(8'h02, 8'h01, 3'b000, 8'h03);
        send(8'h03, 8'h01, 3'b000, 8'h04);
        send(8'h04, 8'h01, 3'b000, 8'h05);
        idle();
        repeat (2) @(negedge clk);
        check("pre_rst_count", int'(count_o), 3);
        check("pre_rst_valid", int'(res_valid_o), 1);
        @(posedge clk); #1;
        reset       = 1'b1;
        cmd_valid_i = 1'b1;
        res_ready_i = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset       = 1'b0;
        cmd_valid_i = 1'b0;
        @(negedge clk);
        check("mrst_count", int'(count_o), 0);
        check("mrst_valid", int'(res_valid_o), 0);
        check("mrst_data", int'(res_data_o), 0);
        check("mrst_ready", int'(cmd_ready_o), 1);
        repeat (6) @(negedge clk);

        // Idle outputs, then a single handshake.
        check("idle_alu", int'({alu_a_o, alu_b_o, alu_op_o}), 0);
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        send(8'h12, 8'h21, 3'b101, 8'h33);
        idle();
        repeat (2) @(negedge clk);
        check("one_valid", int'(res_valid_o), 1);
        @(posedge clk); #1;
        res_ready_i = 1'b1;
        @(posedge clk); #1;
        res_ready_i = 1'b0;
        @(negedge clk);
        check("one_cleared", int'(res_valid_o), 0);
        check("one_data_hold", int'(res_data_o), 8'h33);
        check("one_op_hold", int'(res_op_o), 3'b101);
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
